// File: rtl/ram_arbiter2_pkg.sv
// Shared defaults, requester ids and the read-tag type for the two-port RAM arbiter.
package ram_arb_pkg;

   localparam int DEF_AW      = 4;
   localparam int DEF_DW      = 4;
   localparam int DEF_RAM_LAT = 1;

   localparam logic REQ_HOST   = 1'b0;
   localparam logic REQ_ENGINE = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

endpackage

// File: rtl/ram_arbiter2_if.sv
// Bus bundle joining the host, the pattern/scrub engine, the arbiter and the RAM port.
// Lock lines exist only when ARB_LOCK_EN is defined.
interface ram_arbiter2_if
   import ram_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) ();

   logic          r0_req, r0_we, r0_gnt, r0_rvalid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic          r1_req, r1_we, r1_gnt, r1_rvalid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_add;
   logic [DW-1:0] ram_data_in, ram_data_out;
`ifdef ARB_LOCK_EN
   logic          r0_lock, r1_lock;
`endif

   // Requesters plus the RAM macro side.
   modport master (
`ifdef ARB_LOCK_EN
      output r0_lock, r1_lock,
`endif
      output r0_req, r0_we, r0_addr, r0_wdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      input  r0_gnt, r0_rvalid, r0_rdata,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  ram_we, ram_add, ram_data_in,
      output ram_data_out
   );

   modport slave (
`ifdef ARB_LOCK_EN
      input  r0_lock, r1_lock,
`endif
      input  r0_req, r0_we, r0_addr, r0_wdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      output r0_gnt, r0_rvalid, r0_rdata,
      output r1_gnt, r1_rvalid, r1_rdata,
      output ram_we, ram_add, ram_data_in,
      input  ram_data_out
   );

endinterface

// File: rtl/ram_arbiter2_rr.sv
// Two-way round-robin grant logic with the priority pointer (module rr_arbiter2).
// With ARB_LOCK_EN a granted requester holding lock keeps ownership.
module rr_arbiter2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
`ifdef ARB_LOCK_EN
   input  logic [1:0] lock_i,
`endif
   output logic [1:0] gnt_o,
   output logic       winner_o
);

   logic prio_q, prio_d;
   logic anyGnt;
`ifdef ARB_LOCK_EN
   logic lockAct_q, lockAct_d, lockOwner_q, lockOwner_d;
`endif

   always_comb begin
      winner_o = prio_q;
      anyGnt   = 1'b0;
      gnt_o    = 2'b00;
      prio_d   = prio_q;
      if (req_i[0] && req_i[1]) begin
         winner_o = prio_q;
         anyGnt   = 1'b1;
      end else if (req_i[0]) begin
         winner_o = REQ_HOST;
         anyGnt   = 1'b1;
      end else if (req_i[1]) begin
         winner_o = REQ_ENGINE;
         anyGnt   = 1'b1;
      end
`ifdef ARB_LOCK_EN
      lockAct_d   = 1'b0;
      lockOwner_d = lockOwner_q;
      if (lockAct_q && req_i[lockOwner_q] && lock_i[lockOwner_q]) begin
         winner_o = lockOwner_q;
         anyGnt   = 1'b1;
      end
      if (anyGnt && lock_i[winner_o]) begin
         lockAct_d   = 1'b1;
         lockOwner_d = winner_o;
      end
`endif
      // Pointer always names the loser, so a lock holder leaves it parked on the other side.
      if (anyGnt) begin
         gnt_o[winner_o] = 1'b1;
         prio_d          = ~winner_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q      <= REQ_HOST;
`ifdef ARB_LOCK_EN
         lockAct_q   <= 1'b0;
         lockOwner_q <= REQ_HOST;
`endif
      end else begin
         prio_q      <= prio_d;
`ifdef ARB_LOCK_EN
         lockAct_q   <= lockAct_d;
         lockOwner_q <= lockOwner_d;
`endif
      end
   end

endmodule

// File: rtl/ram_arbiter2.sv
// Two-port arbiter/sequencer for the shared 16x4 synchronous-read RAM.
// Optional macro ARB_LOCK_EN adds locked ownership via r0_lock/r1_lock.
module ram_arbiter2
   import ram_arb_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int RAM_LAT = DEF_RAM_LAT
) (
   input  logic           clk,
   input  logic           rst_n,
   ram_arbiter2_if.slave  bus
);

   logic [1:0]    gnt;
   logic          winner, anyGnt;
   logic          selWe;
   logic [AW-1:0] selAddr;
   logic [DW-1:0] selWdata;

   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_add_q, ram_add_d;
   logic [DW-1:0] ram_data_in_q, ram_data_in_d;
   logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   rd_tag_t       tag_d;
   rd_tag_t       tag_q [0:RAM_LAT];

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    ({bus.r1_req, bus.r0_req}),
`ifdef ARB_LOCK_EN
      .lock_i   ({bus.r1_lock, bus.r0_lock}),
`endif
      .gnt_o    (gnt),
      .winner_o (winner)
   );

   assign anyGnt   = |gnt;
   assign selWe    = winner ? bus.r1_we    : bus.r0_we;
   assign selAddr  = winner ? bus.r1_addr  : bus.r0_addr;
   assign selWdata = winner ? bus.r1_wdata : bus.r0_wdata;

   always_comb begin
      ram_we_d      = 1'b0;
      ram_add_d     = ram_add_q;
      ram_data_in_d = ram_data_in_q;
      tag_d         = '0;
      if (anyGnt) begin
         ram_we_d      = selWe;
         ram_add_d     = selAddr;
         ram_data_in_d = selWdata;
         tag_d.valid   = ~selWe;
         tag_d.id      = winner;
      end
   end

   // Capture read data one stage before the tag reaches the end, so rvalid and rdata line up.
   always_comb begin
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      if (tag_q[RAM_LAT-1].valid) begin
         if (tag_q[RAM_LAT-1].id == REQ_HOST) rdata0_d = bus.ram_data_out;
         else                                 rdata1_d = bus.ram_data_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_we_q      <= 1'b0;
         ram_add_q     <= '0;
         ram_data_in_q <= '0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         for (int i = 0; i <= RAM_LAT; i++) tag_q[i] <= '0;
      end else begin
         ram_we_q      <= ram_we_d;
         ram_add_q     <= ram_add_d;
         ram_data_in_q <= ram_data_in_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         tag_q[0]      <= tag_d;
         for (int i = 1; i <= RAM_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign bus.r0_gnt      = gnt[0];
   assign bus.r1_gnt      = gnt[1];
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_add     = ram_add_q;
   assign bus.ram_data_in = ram_data_in_q;
   assign bus.r0_rdata    = rdata0_q;
   assign bus.r1_rdata    = rdata1_q;
   assign bus.r0_rvalid   = tag_q[RAM_LAT].valid && (tag_q[RAM_LAT].id == REQ_HOST);
   assign bus.r1_rvalid   = tag_q[RAM_LAT].valid && (tag_q[RAM_LAT].id == REQ_ENGINE);

endmodule

// File: tb/tb_ram_arbiter2.sv
// Scoreboard bench for ram_arbiter2 with a behavioural 16x4 RAM behind the command registers.
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_ram_arbiter2;
   import ram_arb_pkg::*;

   typedef struct {
      int         due;
      bit         id;
      logic [3:0] data;
   } rdExp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic preload;
   logic [3:0] mem [16];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit         modelPrio, lockAct, lockOwner;
   logic       expWe;
   logic [3:0] expAdd, expDin;
   logic [3:0] expRdata [2];
   logic [3:0] shadow [16];
   rdExp_t     pend [$];

   always #5 clk = ~clk;

   ram_arbiter2_if bus ();

   ram_arbiter2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural RAM: written from the registered command, read from the registered address.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 4'(i * 7 + 3);
      end else if (bus.ram_we) begin
         mem[bus.ram_add] <= bus.ram_data_in;
      end
   end
   assign bus.ram_data_out = mem[bus.ram_add];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d: got 0x%0h expected 0x%0h", tag, cyc, actual, expected);
      end
   endtask

   task automatic resetModel();
      modelPrio = 1'b0;
      lockAct   = 1'b0;
      lockOwner = 1'b0;
      expWe     = 1'b0;
      expAdd    = '0;
      expDin    = '0;
      expRdata[0] = '0;
      expRdata[1] = '0;
      pend.delete();
   endtask

   task automatic driveIdle();
      bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
      bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
`ifdef ARB_LOCK_EN
      bus.r0_lock = 1'b0; bus.r1_lock = 1'b0;
`endif
   endtask

   // Reset lands mid-cycle, before the next active edge, so in-flight tags must vanish at once.
   task automatic applyReset();
      driveIdle();
      #2;
      rst_n = 1'b0;
      #1;
      resetModel();
      checkOutput("rst_ram_we", 32'(bus.ram_we), 0);
      checkOutput("rst_ram_add", 32'(bus.ram_add), 0);
      checkOutput("rst_ram_din", 32'(bus.ram_data_in), 0);
      checkOutput("rst_r0_rvalid", 32'(bus.r0_rvalid), 0);
      checkOutput("rst_r1_rvalid", 32'(bus.r1_rvalid), 0);
      checkOutput("rst_r0_rdata", 32'(bus.r0_rdata), 0);
      checkOutput("rst_r1_rdata", 32'(bus.r1_rdata), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input bit q0, input bit w0, input logic [3:0] a0, input logic [3:0] d0, input bit l0,
                                input bit q1, input bit w1, input logic [3:0] a1, input logic [3:0] d1, input bit l1);
      bit e0, e1, has, win, locked, we;
      logic [3:0] a, d;
      rdExp_t rd;
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         rd = pend.pop_front();
         if (rd.id) e1 = 1'b1; else e0 = 1'b1;
         expRdata[rd.id] = rd.data;
      end
      checkOutput("r0_rvalid", 32'(bus.r0_rvalid), 32'(e0));
      checkOutput("r1_rvalid", 32'(bus.r1_rvalid), 32'(e1));
      checkOutput("r0_rdata", 32'(bus.r0_rdata), 32'(expRdata[0]));
      checkOutput("r1_rdata", 32'(bus.r1_rdata), 32'(expRdata[1]));
      checkOutput("ram_we", 32'(bus.ram_we), 32'(expWe));
      checkOutput("ram_add", 32'(bus.ram_add), 32'(expAdd));
      checkOutput("ram_data_in", 32'(bus.ram_data_in), 32'(expDin));

      bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0;
      bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
`ifdef ARB_LOCK_EN
      bus.r0_lock = l0; bus.r1_lock = l1;
      locked = lockAct && (lockOwner ? (q1 && l1) : (q0 && l0));
`else
      locked = 1'b0;
`endif
      #1;
      has = 1'b1;
      win = 1'b0;
      if (locked)        win = lockOwner;
      else if (q0 && q1) win = modelPrio;
      else if (q0)       win = 1'b0;
      else if (q1)       win = 1'b1;
      else               has = 1'b0;
      checkOutput("r0_gnt", 32'(bus.r0_gnt), 32'(has && !win));
      checkOutput("r1_gnt", 32'(bus.r1_gnt), 32'(has && win));

      if (has) begin
         we = win ? w1 : w0;
         a  = win ? a1 : a0;
         d  = win ? d1 : d0;
         modelPrio = ~win;
         lockAct   = win ? l1 : l0;
         lockOwner = win;
         expWe  = we;
         expAdd = a;
         expDin = d;
         if (we) shadow[a] = d;
         else    pend.push_back('{due: cyc + 1 + DEF_RAM_LAT, id: win, data: shadow[a]});
      end else begin
         expWe   = 1'b0;
         lockAct = 1'b0;
      end
`ifndef ARB_LOCK_EN
      lockAct = 1'b0;
`endif
      cyc++;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      preload = 1'b1;
      for (int i = 0; i < 16; i++) shadow[i] = 4'(i * 7 + 3);
      applyReset();
      preload = 1'b0;

      // Host write then read-back of the same address.
      applyStimulus(1, 1, 4'd3, 4'hA, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 4'd3, 4'h0, 0, 0, 0, 0, 0, 0);
      idleCycles(3);

      // Continuous conflict from a fresh pointer: strict alternation.
      applyReset();
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'd1, 0, 0, 1, 0, 4'd2, 0, 0);
      idleCycles(3);

      // Engine alone three times, then a conflict that the host must win.
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd4, 0, 0);
      applyStimulus(1, 0, 4'd9, 0, 0, 1, 0, 4'd10, 0, 0);
      idleCycles(4);

      // Host write, engine read of the same address on the next grant.
      applyStimulus(1, 1, 4'd5, 4'h7, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd5, 0, 0);
      idleCycles(3);

      // Reads in flight when reset hits.
      applyStimulus(1, 0, 4'd6, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'd7, 0, 0);
      applyReset();
      idleCycles(4);

`ifdef ARB_LOCK_EN
      // Engine locks for three grants against a continuously requesting host.
      applyStimulus(1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 4'd11, 0, 0, 1, 0, 4'd12, 0, 1);
      applyStimulus(1, 0, 4'd11, 0, 0, 0, 0, 0, 0, 0);
      idleCycles(3);
`endif

      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      end
      idleCycles(4);
      checkOutput("pending_drained", 32'(pend.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_arbiter2.md
Name: ram_arbiter2

Overview:
- Two-port arbiter and sequencer for the shared 16x4 synchronous-read RAM.
- Lets two requesters share the single RAM port: requester 0 is the pad-side host, requester 1 is the on-chip pattern/scrub engine.
- Grants one single-cycle transaction per clock using round-robin priority.
- Registers the RAM command and returns read data with a fixed, tagged latency.

Parameters:
- AW, 4: RAM address width.
- DW, 4: RAM data width.
- RAM_LAT, 1: cycles from RAM command (registered inputs) to valid ram_data_out.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- r0_req  in  1  requester 0 transaction request
- r0_we  in  1  1=write, 0=read
- r0_addr  in  AW  address
- r0_wdata  in  DW  write data
- r0_gnt  out  1  request accepted this cycle (combinational)
- r0_rvalid  out  1  read data valid
- r0_rdata  out  DW  read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: identical to the r0_* ports, for requester 1
- ram_we  out  1  RAM write enable (registered)
- ram_add  out  AW  RAM address (registered)
- ram_data_in  out  DW  RAM write data (registered)
- ram_data_out  in  DW  RAM read data

Behaviour:
- Clocking: one clock, clk. Reset: rst_n is asynchronous, active-low.
- Reset values:
  - ram_we=0, ram_add=0, ram_data_in=0.
  - rN_rvalid=0, rN_rdata=0.
  - Priority pointer prio=0, so requester 0 wins the first conflict.
  - Read-tag pipeline cleared.
- Grant logic (combinational):
  - At most one grant per cycle.
  - Both requesting: grant goes to prio.
  - One requesting: grant goes to that requester.
  - None requesting: no grant.
- Pointer update: on any grant, prio <= the other requester. No grant: prio holds.
- Handshake:
  - A transaction transfers when rN_req & rN_gnt.
  - A requester holds req and its fields stable until it sees gnt.
  - A request dropped before grant is discarded with no side effect.
  - There are no multi-cycle transactions.
- Command path, for a grant in cycle T:
  - At the clk edge ending T, ram_we/ram_add/ram_data_in load the winner's fields.
  - With no grant, ram_we <= 0 and ram_add/ram_data_in hold their previous values.
- Read return:
  - A granted read is tagged {valid, id} into a shift pipeline of depth 1+RAM_LAT.
  - In cycle T+1+RAM_LAT, the owning rN_rvalid=1 for exactly one cycle.
  - The owning rN_rdata is registered from ram_data_out at that point.
  - The other rvalid stays 0; non-owner rdata holds its last value.
- Writes produce no rvalid.
- Throughput: one transaction per cycle; back-to-back grants may alternate or repeat freely, and read returns keep order.
- Read-after-write to the same address in consecutive grants returns the new data, because the RAM write precedes the read.
- Reset mid-operation: in-flight tags are flushed immediately and no rvalid fires for pre-reset reads. After release, the first conflict again goes to requester 0.
- Address arithmetic: none; the address is passed through unchanged.

Optional Feature:
- Macro ARB_LOCK_EN adds ports r0_lock and r1_lock (in, 1).
  - Locked ownership: when a granted requester asserts lock alongside req, it wins every following cycle in which it requests, even against the other requester. The pointer does not rotate while it holds the lock.
  - Releasing: ownership ends on the first cycle in which the owner has lock=0 or req=0. After release, the pointer points to the other requester.
- Without ARB_LOCK_EN, the lock ports do not exist and behaviour is pure round-robin.

Decomposition:
- Package ram_arb_pkg holds:
  - the AW/DW/RAM_LAT defaults
  - requester-id constants REQ_HOST=0 and REQ_ENGINE=1
  - the read-tag struct {valid, id}
- Sub-module rr_arbiter2 holds the prio register and the grant/lock logic.
- The top level holds the command registers and the tag/rdata pipeline.

Test Plan:
1. Reset, then r0 alone writes addr 3 data 0xA; next cycle r0 reads addr 3 -> r0_gnt=1 both cycles. ram_we=1/ram_add=3/ram_data_in=0xA after the first edge. r0_rvalid=1 with r0_rdata=0xA two cycles after the read grant.
2. Both request reads every cycle for 4 cycles (r0 addr 1, r1 addr 2) -> grants go r0,r1,r0,r1. rvalid alternates in the same order with each requester's own data.
3. r1 holds req for 3 cycles while r0 is idle -> r1 is granted 3 times. prio ends at 0, so the next conflict goes to r0.
4. r0 write addr 5=0x7 granted, then r1 read addr 5 granted the next cycle -> r1_rdata=0x7, and r0_rvalid stays 0 throughout.
5. Two reads in flight, then rst_n pulsed low mid-flight -> all outputs go to 0 immediately and no rvalid appears after release.
6. (ARB_LOCK_EN) r1 locks for 3 cycles while r0 requests continuously -> r1 is granted 3 cycles; r0 is granted in the cycle after r1 drops lock.
